// File: rtl/evo_test_pkg.sv
// Shared types and default constants for the evolved-candidate truth-table scanner.
package evo_test_pkg;

    localparam int unsigned DEF_IN_WIDTH      = 4;
    localparam int unsigned DEF_SETTLE_CYCLES = 16;
    localparam int unsigned DEF_SAMPLES       = 8;
    localparam int unsigned SYNC_STAGES       = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        REPORT = 2'd3
    } scan_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/evo_truth_table_scanner_bit_sync.sv
// Multi-flop synchroniser for the candidate's asynchronous output, synchronous active-low reset.
module bit_sync
    import evo_test_pkg::*;
#(
    parameter int unsigned STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/evo_truth_table_scanner.sv
// Drives every input vector onto an evolved 4-in/1-out candidate and captures its truth table.
// Optional STABILITY_CHECK_EN: multi-sample instability detection; otherwise one sample per vector.
module evo_truth_table_scanner
    import evo_test_pkg::*;
#(
    parameter int unsigned IN_WIDTH      = DEF_IN_WIDTH,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned SAMPLES       = DEF_SAMPLES
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic [IN_WIDTH-1:0]      dut_in,
    input  logic                     dut_out,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic [(2**IN_WIDTH)-1:0] truth_table,
    output logic [(2**IN_WIDTH)-1:0] unstable_mask
);

    localparam int unsigned TABLE_W = 2**IN_WIDTH;
    localparam int unsigned CNT_W   = $clog2(max_u(SETTLE_CYCLES, SAMPLES) + 1);

    scan_state_t         state;
    logic [IN_WIDTH-1:0] vec;
    logic [CNT_W-1:0]    cnt;
    logic                sync_out;
    logic                last_sample;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (dut_out),
        .q     (sync_out)
    );

`ifdef STABILITY_CHECK_EN
    logic [TABLE_W-1:0] unstable_q;

    assign last_sample   = (cnt == CNT_W'(SAMPLES - 1));
    assign unstable_mask = unstable_q;
`else
    assign last_sample   = 1'b1;
    assign unstable_mask = '0;
`endif

    // The candidate sees the scan index directly; it rests at 0 outside a scan.
    assign dut_in = vec;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            vec          <= '0;
            cnt          <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            truth_table  <= '0;
`ifdef STABILITY_CHECK_EN
            unstable_q   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= SETTLE;
                        vec         <= '0;
                        cnt         <= '0;
                        busy        <= 1'b1;
                        truth_table <= '0;
`ifdef STABILITY_CHECK_EN
                        unstable_q  <= '0;
`endif
                    end
                end

                SETTLE: begin
                    if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                SAMPLE: begin
                    // First sample is the reference; later ones only flag divergence.
                    if (cnt == '0) begin
                        truth_table[vec] <= sync_out;
                    end
`ifdef STABILITY_CHECK_EN
                    else if (sync_out != truth_table[vec]) begin
                        unstable_q[vec] <= 1'b1;
                    end
`endif
                    if (last_sample) begin
                        cnt <= '0;
                        vec <= vec + IN_WIDTH'(1);
                        if (vec == {IN_WIDTH{1'b1}}) begin
                            state        <= REPORT;
                            result_valid <= 1'b1;
                        end else begin
                            state <= SETTLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                REPORT: begin
                    if (result_ready) begin
                        state        <= IDLE;
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/evo_truth_table_scanner.md
# evo_truth_table_scanner

Stimulus-and-capture stage that sits directly around one evolved 4-input/1-output combinational candidate. It drives every input vector onto the candidate in turn. It synchronises the candidate's asynchronous output and samples it after a settle window, flagging any output that changes during that window. It then delivers the 16-entry truth table plus an instability mask to the downstream reporting logic over a valid/ready handshake.

## Interface
- IN_WIDTH, 4, width of candidate input bus; table width is 2**IN_WIDTH
- SETTLE_CYCLES, 16, cycles waited after each vector change before sampling; legal range ≥3
- SAMPLES, 8, consecutive samples taken per vector; legal range ≥1
- clk  in  1  single clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin a scan; honoured only in IDLE
- busy  out  1  high from the start-accept edge until the result handshake completes; reset 0
- dut_in  out  IN_WIDTH  vector driven to the candidate; reset 0
- dut_out  in  1  candidate output, asynchronous to clk
- result_valid  out  1  result available; reset 0
- result_ready  in  1  downstream accepts result
- truth_table  out  2**IN_WIDTH  bit k = sampled output for input k; reset 0
- unstable_mask  out  2**IN_WIDTH  bit k = output changed while sampling vector k; reset 0

## Operation
- dut_out passes through a 2-flop synchroniser (reset 0) before any use.
- States:
  - IDLE: waiting.
  - SETTLE: counter runs SETTLE_CYCLES cycles.
  - SAMPLE: SAMPLES cycles.
  - REPORT: result_valid high.
- IDLE + start → SETTLE. vec=0, truth_table and unstable_mask cleared, busy=1.
- SETTLE → SAMPLE when the counter expires.
- SAMPLE, first cycle: record the synchronised bit into truth_table[vec].
- SAMPLE, later cycles: any sample differing from the first sets unstable_mask[vec].
- SAMPLE, last cycle, vec≠max: vec increments, state → SETTLE.
- SAMPLE, last cycle, vec=max: vec wraps to 0, state → REPORT.
- dut_in = vec at all times, so it is 0 in IDLE and REPORT.
- REPORT: truth_table and unstable_mask hold stable. On result_valid & result_ready → IDLE, result_valid=0, busy=0. Outputs keep their last values until the next start.
- start while busy: ignored. start in the same cycle as the handshake: ignored; state is IDLE next cycle.
- rst_n low at any point, mid-scan included: every register, synchroniser flops included, returns to its reset value at the next edge. No partial result is delivered.

## Timing
- Per vector: SETTLE_CYCLES + SAMPLES cycles.
- result_valid rises 2**IN_WIDTH × (SETTLE_CYCLES + SAMPLES) cycles after the start-accept edge. Defaults: 384 with the macro, 272 without.
- SETTLE_CYCLES ≥3 guarantees the synchroniser reflects the new vector's response before the first sample, apart from the candidate's own delay.
- result_valid stays high indefinitely while result_ready is low.

## Configuration
- STABILITY_CHECK_EN defined: behaviour as above.
- STABILITY_CHECK_EN undefined:
  - SAMPLE lasts exactly one cycle regardless of SAMPLES.
  - unstable_mask is tied to 0.
  - Comparison logic is removed.

## Structure
- Shared package evo_test_pkg holds:
  - state enum (IDLE, SETTLE, SAMPLE, REPORT)
  - SYNC_STAGES = 2
  - default-parameter constants
- Sub-module bit_sync: the 2-flop synchroniser, with synchronous active-low reset, instantiated once.

## Test plan
- Bench model dut_out = in[0]^in[3], defaults → truth_table=16'h55AA, unstable_mask=16'h0000, result_valid exactly 384 cycles after start.
- Model constant 1 → truth_table=16'hFFFF. Constant 0 → 16'h0000.
- Model toggles every cycle when dut_in=4'h6, otherwise out=in[1] → unstable_mask=16'h0040 with the macro defined, 16'h0000 without it.
- Hold result_ready low 10 cycles in REPORT while pulsing start → outputs and busy hold. Ready high for 1 cycle → IDLE next cycle, no new scan.
- Assert rst_n low while dut_in=4'h7 → next cycle busy=0, dut_in=0, result_valid=0. A new start produces a complete fresh scan with correct table.
- Undefined macro, defaults → result_valid 272 cycles after start, same truth_table as the first scenario.
